// File: rtl/mode_sched.sv
// Mode scheduler: debounced button and Bluetooth requests, brake dwell before
// each mode commit, and a timed recovery hold while fault is asserted.
module mode_sched #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int DWELL_CYC    = 25_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       bt_valid,
  input  logic [1:0] bt_mode,
  input  logic       fault,
  output logic [1:0] mode,
  output logic       motor_en,
  output logic       busy,
  output logic       ack,
  output logic       req_drop
);

  localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int DW_W = $clog2(DWELL_CYC);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL_CYC - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BRAKE  = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;
  localparam logic [1:0] FAULT  = 2'd3;

  logic            key_s1, key_s2, key_last;
  logic            armed, press;
  logic [DB_W-1:0] db_cnt;

  logic [1:0]      state, target, req_target;
  logic [DW_W-1:0] dwell;
  logic            any_req, both_req;

  // Counter saturates once the synced level is stable; the level then either
  // re-arms (high) or fires a single press while armed (low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1   <= 1'b1;
      key_s2   <= 1'b1;
      key_last <= 1'b1;
      armed    <= 1'b1;
      press    <= 1'b0;
      db_cnt   <= '0;
    end else begin
      key_s1   <= key_n;
      key_s2   <= key_s1;
      key_last <= key_s2;
      press    <= 1'b0;
      if (key_s2 != key_last) begin
        db_cnt <= '0;
      end else if (db_cnt != DB_LAST) begin
        db_cnt <= db_cnt + 1'b1;
      end else if (key_s2) begin
        armed <= 1'b1;
      end else if (armed) begin
        press <= 1'b1;
        armed <= 1'b0;
      end
    end
  end

  always_comb begin
    any_req    = press | bt_valid;
    both_req   = press & bt_valid;
    req_target = bt_valid ? bt_mode : mode + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      target   <= '0;
      dwell    <= '0;
      mode     <= '0;
      motor_en <= 1'b0;
      busy     <= 1'b0;
      ack      <= 1'b0;
      req_drop <= 1'b0;
    end else begin
      ack      <= 1'b0;
      req_drop <= 1'b0;
      if (fault) begin
        state    <= FAULT;
        dwell    <= '0;
        motor_en <= 1'b0;
        busy     <= 1'b1;
        req_drop <= any_req;
      end else begin
        case (state)
          IDLE: begin
            motor_en <= 1'b1;
            busy     <= 1'b0;
            req_drop <= both_req;
            if (any_req && (req_target != mode)) begin
              target   <= req_target;
              dwell    <= '0;
              state    <= BRAKE;
              motor_en <= 1'b0;
              busy     <= 1'b1;
            end
          end
          BRAKE: begin
            req_drop <= any_req;
            if (dwell == DW_LAST) state <= SWITCH;
            else                  dwell <= dwell + 1'b1;
          end
          SWITCH: begin
            req_drop <= any_req;
            mode     <= target;
            ack      <= 1'b1;
            motor_en <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
          FAULT: begin
            req_drop <= any_req;
            if (dwell == DW_LAST) begin
              state    <= IDLE;
              dwell    <= '0;
              motor_en <= 1'b1;
              busy     <= 1'b0;
            end else begin
              dwell <= dwell + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mode_sched.sv
// Bench for mode_sched: a cycle-time reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mode_sched;

  localparam int D = 4;
  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic       bt_valid = 1'b0;
  logic [1:0] bt_mode = 2'd0;
  logic       fault = 1'b0;
  logic [1:0] mode;
  logic       motor_en, busy, ack, req_drop;

  int errors = 0;
  int checks = 0;
  int ack_cnt = 0;

  mode_sched #(.DEBOUNCE_CYC(D), .DWELL_CYC(W)) dut (
    .clk(clk), .rst_n(rst_n), .key_n(key_n), .bt_valid(bt_valid),
    .bt_mode(bt_mode), .fault(fault), .mode(mode), .motor_en(motor_en),
    .busy(busy), .ack(ack), .req_drop(req_drop)
  );

  always #5 clk = ~clk;

  // Reference model: time-based view of requests, dwell deadlines and fault hold
  logic [1:0] m_mode = 2'd0, m_target = 2'd0;
  logic m_motor = 1'b0, m_busy = 1'b0, m_ack = 1'b0, m_drop = 1'b0;
  bit   m_pending = 0, m_fault = 0, m_armed = 1;
  int   cyc = 0, m_commit = 0, m_run = 0, lowrun = 0, highrun = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_mode = 2'd0; m_target = 2'd0; m_motor = 0; m_busy = 0;
        m_ack = 0; m_drop = 0; m_pending = 0; m_fault = 0; m_armed = 1;
        m_run = 0; lowrun = 0; highrun = 0;
      end else begin
        bit press, anyreq;
        int tgt;
        cyc++;
        if (!key_n) begin lowrun++; highrun = 0; end
        else begin highrun++; lowrun = 0; end
        press = m_armed && (lowrun == D + 4);
        if (press) m_armed = 0;
        if (highrun >= D + 3) m_armed = 1;
        anyreq = press || bt_valid;
        m_ack = 0;
        m_drop = 0;
        if (fault) begin
          m_fault = 1; m_pending = 0; m_run = 0;
          m_motor = 0; m_busy = 1; m_drop = anyreq;
        end else if (m_fault) begin
          m_drop = anyreq;
          m_run++;
          if (m_run == W) begin m_fault = 0; m_motor = 1; m_busy = 0; end
        end else if (m_pending) begin
          m_drop = anyreq;
          if (cyc == m_commit) begin
            m_mode = m_target; m_ack = 1; m_motor = 1; m_busy = 0; m_pending = 0;
          end
        end else begin
          m_motor = 1; m_busy = 0;
          m_drop = press && bt_valid;
          if (anyreq) begin
            tgt = bt_valid ? int'(bt_mode) : (int'(m_mode) + 1) % 4;
            if (tgt != int'(m_mode)) begin
              m_target = 2'(tgt); m_pending = 1; m_commit = cyc + W + 1;
              m_motor = 0; m_busy = 1;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({mode, motor_en, busy, ack, req_drop} !== {m_mode, m_motor, m_busy, m_ack, m_drop}) begin
      errors++;
      $display("FAIL cycle_model t=%0t: mode/motor/busy/ack/drop got %0d/%b/%b/%b/%b expected %0d/%b/%b/%b/%b",
               $time, mode, motor_en, busy, ack, req_drop, m_mode, m_motor, m_busy, m_ack, m_drop);
    end
    if (ack === 1'b1) ack_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic bt_req(input logic [1:0] m);
    bt_valid = 1'b1;
    bt_mode  = m;
    tick(1);
    bt_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. reset
    tick(3);
    chk("rst_mode", mode, 0);
    chk("rst_motor", motor_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", ack, 0);
    rst_n = 1'b1;
    tick(1);
    chk("first_edge_motor", motor_en, 1);

    // 2. bluetooth request, latency W+1
    bt_req(2'd2);
    chk("bt_e0_motor", motor_en, 0);
    chk("bt_e0_busy", busy, 1);
    tick(8);
    chk("bt_e8_mode", mode, 0);
    tick(1);
    chk("bt_e9_mode", mode, 2);
    chk("bt_e9_ack", ack, 1);
    chk("bt_e9_motor", motor_en, 1);
    chk("bt_e9_busy", busy, 0);
    tick(1);
    chk("bt_e10_ack", ack, 0);

    // 3. button stepping
    bt_req(2'd0);
    tick(12);
    chk("to_zero_mode", mode, 0);
    key_n = 1'b0;
    tick(2);
    key_n = 1'b1;
    tick(15);
    chk("glitch_mode", mode, 0);
    ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      key_n = 1'b0;
      tick(10);
      key_n = 1'b1;
      tick(10);
      chk("press_mode", mode, (i + 1) % 4);
    end
    chk("press_acks", ack_cnt, 4);

    // 4. arbitration and drop in BRAKE
    key_n = 1'b0;
    tick(7);
    bt_valid = 1'b1;
    bt_mode  = 2'd3;
    tick(1);
    bt_valid = 1'b0;
    key_n = 1'b1;
    chk("arb_drop", req_drop, 1);
    chk("arb_busy", busy, 1);
    tick(1);
    chk("arb_drop_clear", req_drop, 0);
    tick(1);
    bt_req(2'd1);
    chk("brake_drop", req_drop, 1);
    tick(10);
    chk("arb_final_mode", mode, 3);

    // 5. fault during BRAKE, recovery, no-op request
    ack_cnt = 0;
    bt_req(2'd1);
    tick(2);
    fault = 1'b1;
    tick(1);
    chk("fault_motor", motor_en, 0);
    chk("fault_busy", busy, 1);
    chk("fault_mode", mode, 3);
    bt_req(2'd2);
    chk("fault_drop", req_drop, 1);
    tick(2);
    fault = 1'b0;
    tick(7);
    chk("recover_7_motor", motor_en, 0);
    tick(1);
    chk("recover_8_motor", motor_en, 1);
    chk("recover_8_busy", busy, 0);
    chk("fault_no_ack", ack_cnt, 0);
    chk("fault_keep_mode", mode, 3);
    bt_req(2'd3);
    chk("noop_ack", ack, 0);
    chk("noop_drop", req_drop, 0);
    chk("noop_motor", motor_en, 1);
    tick(12);
    chk("noop_acks", ack_cnt, 0);

    // 6. reset mid-operation
    bt_req(2'd2);
    tick(12);
    chk("pre_rst_mode", mode, 2);
    bt_req(2'd1);
    tick(4);
    rst_n = 1'b0;
    #2;
    chk("async_rst_mode", mode, 0);
    chk("async_rst_motor", motor_en, 0);
    chk("async_rst_busy", busy, 0);
    tick(2);
    rst_n = 1'b1;
    ack_cnt = 0;
    tick(20);
    chk("no_stale_ack", ack_cnt, 0);
    chk("no_stale_mode", mode, 0);
    chk("post_rst_motor", motor_en, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mode_sched.md
Name: mode_sched

Overview:
- Mode scheduler that sits in front of the car's working-mode selector and drives its 2-bit mode input.
- Accepts mode-change requests from two sources: a debounced push-button that steps through modes, and a Bluetooth command carrying a direct mode code.
- Arbitrates between the two sources and enforces a motor-brake dwell before every mode change.
- Holds the car stopped while a fault input is active.

Parameters:
- DEBOUNCE_CYC, 1_000_000: cycles key_n must be stable (low for a press, high for a release); 20 ms at 50 MHz.
- DWELL_CYC, 25_000_000: brake dwell before a mode commit, and fault recovery time; 0.5 s at 50 MHz. Minimum value 2.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- key_n  in  1  mode button, active low, asynchronous to clk.
- bt_valid  in  1  one-cycle strobe: bt_mode is valid.
- bt_mode  in  2  requested mode code from the Bluetooth decoder.
- fault  in  1  level; stop request (obstacle or low battery).
- mode  out  2  current mode; feeds the mode selector's data input.
- motor_en  out  1  1 = motor drivers allowed to run.
- busy  out  1  1 while in BRAKE, SWITCH or FAULT.
- ack  out  1  one-cycle pulse on a mode commit.
- req_drop  out  1  one-cycle pulse when a request is discarded.

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active low.
- Reset values: mode=0, motor_en=0, busy=0, ack=0, req_drop=0, state=IDLE, all counters 0.
- Registered outputs: all outputs are registered.
- First edge after release: on the first edge after rst_n deasserts, motor_en=1 if fault=0.
- Button synchroniser: key_n passes through a 2-FF synchroniser.
- Button debounce:
  - The debounce counter clears on any change of the synced level.
  - When a low level has been stable for DEBOUNCE_CYC cycles, emit exactly one press event (one-cycle internal pulse).
  - A high level stable for DEBOUNCE_CYC cycles re-arms the detector.
  - Holding the button produces one event only.
- Request target:
  - Press event: target = mode+1 mod 4 (wraps 3 to 0).
  - bt_valid: target = bt_mode.
- Arbitration: if a press event and bt_valid occur in the same cycle, Bluetooth wins and the press is dropped (req_drop pulse).
- FSM states: IDLE, BRAKE, SWITCH, FAULT.
- IDLE:
  - motor_en=1, busy=0.
  - Accepted request with target != mode: latch target, clear the dwell counter, go to BRAKE. On that edge motor_en=0 and busy=1.
  - Request with target == mode: no-op. No ack, no req_drop, no state change.
- BRAKE:
  - motor_en=0.
  - The dwell counter increments every cycle. When it reaches DWELL_CYC-1, go to SWITCH.
  - Any request arriving in BRAKE is dropped (req_drop pulse); the latched target is kept.
- SWITCH (single cycle):
  - On the next edge: mode<=target, ack<=1, motor_en<=1, busy<=0, state<=IDLE.
  - ack clears one edge later.
  - A request arriving during SWITCH is dropped.
- Latency: if bt_valid is sampled at edge E0, the new mode, ack=1 and motor_en=1 are all visible after edge E0+DWELL_CYC+1.
- FAULT entry:
  - fault=1 sampled in any state: go to FAULT on that edge. motor_en=0, busy=1.
  - Any pending target is discarded, mode is unchanged, and there is no ack.
- FAULT behaviour:
  - All requests are dropped (req_drop pulse per request).
  - The dwell counter clears while fault=1 and counts while fault=0.
  - After DWELL_CYC consecutive cycles with fault=0, go to IDLE with motor_en=1 and busy=0.
  - fault re-asserting during recovery restarts the count.
- Fault priority: fault takes priority over request acceptance in the same cycle; that request is dropped.
- Reset mid-operation: rst_n low in any state immediately forces the reset values. The latched target and all counters are lost.
- Counter widths: counters are sized by $clog2 of their parameter. No counter overflows because every counter saturates or clears at its terminal count.

Test Plan (DEBOUNCE_CYC=4, DWELL_CYC=8):
1. Reset:
   - Assert rst_n=0 for 3 cycles with fault=0 → mode=0, motor_en=0, busy=0, ack=0 during reset.
   - Release rst_n → motor_en=1 after the first edge.
2. Bluetooth request:
   - bt_valid=1, bt_mode=2 for one cycle at edge E0 → motor_en=0, busy=1 after E0.
   - mode=2, ack=1, motor_en=1, busy=0 after E9; ack=0 after E10.
3. Button stepping:
   - A 2-cycle low glitch on key_n → no mode change.
   - Four clean presses (low 10, high 10), each allowed to complete → mode steps 0→1→2→3→0.
   - Exactly four ack pulses.
4. Arbitration and drops:
   - Press event coincident with bt_valid (bt_mode=3) from mode 0 → req_drop=1 for one cycle; final mode=3.
   - bt_valid (bt_mode=1) during BRAKE → req_drop pulse; mode still lands on 3.
5. Fault and no-op:
   - fault=1 at BRAKE cycle 3 → FAULT after that edge, motor_en=0, mode unchanged, no ack.
   - fault=0 → motor_en=1 exactly 8 cycles later.
   - bt_mode equal to the current mode → no ack, no req_drop, motor_en stays 1.
6. Reset mid-operation:
   - From mode=2, start a change to mode 1, then pull rst_n low at BRAKE cycle 5 → mode=0, motor_en=0, busy=0 immediately (asynchronous).
   - After release, no stale commit to mode 1 ever occurs.
